// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock-divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } div_state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_counter.sv
// Modulo-N period counter with registered duty compare and period-start tick.
module clk_div_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             start_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             boundary_o,
  output logic             out_clk_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             out_clk_q, out_clk_d;
  logic             tick_q, tick_d;

  assign boundary_o = (cnt_q == (div_i - ONE));

  // A fresh period always starts high (floor(N/2) >= 1), so the duty compare
  // against the old ratio at a boundary is still correct for the new ratio.
  always_comb begin
    cnt_d     = '0;
    out_clk_d = 1'b0;
    tick_d    = 1'b0;
    if (run_i) begin
      cnt_d     = (start_i || boundary_o) ? '0 : cnt_q + ONE;
      out_clk_d = (cnt_d < (div_i >> 1));
      tick_d    = (cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      out_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      out_clk_q <= out_clk_d;
      tick_q    <= tick_d;
    end
  end

  assign out_clk_o = out_clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free divider controller: FSM, pending ratio and cfg handshake.
// cfg handshake: a request transfers on a cycle where cfg_valid && cfg_ready.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out_clk,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div,
  output div_state_t       dbg_state
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_N   = DIV_W'(MIN_DIV);

  div_state_t       state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             accept, take, boundary;

  assign accept = cfg_valid && cfg_ready_q;
  assign take   = accept && (cfg_div >= MIN_N);

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    cfg_err_d = accept && !take;
    case (state_q)
      IDLE: begin
        if (take) cur_div_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (boundary && !en) begin
          // Stopping now: a request taken here behaves like an idle write.
          state_d = IDLE;
          if (take) cur_div_d = cfg_div;
        end else if (take) begin
          pend_d  = cfg_div;
          state_d = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          cur_div_d = pend_q;
          state_d   = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cfg_ready_d = (state_d != PEND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_div_q   <= RST_DIV;
      pend_q      <= RST_DIV;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cur_div_q   <= cur_div_d;
      pend_q      <= pend_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  clk_div_counter #(.DIV_W(DIV_W)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_d != IDLE),
    .start_i    (state_q == IDLE),
    .div_i      (cur_div_q),
    .boundary_o (boundary),
    .out_clk_o  (out_clk),
    .tick_o     (tick)
  );

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign cur_div   = cur_div_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;
  import clk_div_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready, cfg_err, out_clk, tick;
  logic [7:0] cur_div;
  div_state_t dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  logic [1:0] exp_q[$];   // {tick, out_clk} expected per cycle

  always #5 clk = ~clk;

  clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .out_clk   (out_clk),
    .tick      (tick),
    .cur_div   (cur_div),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected waveform of one period: high for floor(N/2) cycles, tick on first.
  task automatic push_period(input int n);
    for (int c = 0; c < n; c++) exp_q.push_back({1'(c == 0), 1'(c < n / 2)});
  endtask

  task automatic expect_cycles(input int n, input string tag);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      step();
      if (exp_q.size() == 0) begin
        check({tag, " queue empty"}, 32'(0), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check(tag, 32'({tick, out_clk}), 32'(e));
      end
    end
  endtask

  task automatic cfg_write(input logic [7:0] d);
    cfg_valid = 1'b1;
    cfg_div   = d;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_clk",   32'(out_clk),   32'(0));
    check("rst tick",      32'(tick),      32'(0));
    check("rst cfg_err",   32'(cfg_err),   32'(0));
    check("rst cfg_ready", 32'(cfg_ready), 32'(1));
    check("rst cur_div",   32'(cur_div),   32'(2));
    check("rst state",     32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // Default divide-by-2
    en = 1'b1;
    push_period(2); push_period(2);
    expect_cycles(4, "div2 wave");
    check("div2 cur_div", 32'(cur_div), 32'(2));
    en = 1'b0;
    step();
    check("div2 stop state", 32'(dbg_state), 32'(IDLE));
    check("div2 stop out",   32'({tick, out_clk}), 32'(2'b00));

    // Idle write N=5 then run
    cfg_write(8'd5);
    check("idle wr cur_div", 32'(cur_div),   32'(5));
    check("idle wr state",   32'(dbg_state), 32'(IDLE));
    check("idle wr ready",   32'(cfg_ready), 32'(1));
    en = 1'b1;
    push_period(5); push_period(5);
    expect_cycles(10, "div5 wave");
    check("div5 ready", 32'(cfg_ready), 32'(1));
    en = 1'b0;
    step();
    check("div5 stop state", 32'(dbg_state), 32'(IDLE));

    // Running N=4, retune to 3 at cnt=1
    cfg_write(8'd4);
    en = 1'b1;
    step();
    check("n4 cnt0", 32'({tick, out_clk}), 32'(2'b11));
    step();
    check("n4 cnt1", 32'({tick, out_clk}), 32'(2'b01));
    cfg_write(8'd3);
    check("n4 cnt2", 32'({tick, out_clk}), 32'(2'b00));
    check("pend ready cnt2", 32'(cfg_ready), 32'(0));
    check("pend state",      32'(dbg_state), 32'(PEND));
    step();
    check("n4 cnt3", 32'({tick, out_clk}), 32'(2'b00));
    check("pend ready cnt3", 32'(cfg_ready), 32'(0));
    check("pend cur_div",    32'(cur_div),   32'(4));
    push_period(3); push_period(3);
    expect_cycles(6, "div3 wave");
    check("div3 cur_div", 32'(cur_div),   32'(3));
    check("div3 ready",   32'(cfg_ready), 32'(1));
    check("div3 state",   32'(dbg_state), 32'(RUN));
    en = 1'b0;
    step();
    check("div3 stop state", 32'(dbg_state), 32'(IDLE));

    // Illegal requests
    cfg_write(8'd1);
    check("err n1 pulse",   32'(cfg_err), 32'(1));
    step();
    check("err n1 clear",   32'(cfg_err), 32'(0));
    check("err n1 cur_div", 32'(cur_div), 32'(3));
    cfg_write(8'd0);
    check("err n0 pulse",   32'(cfg_err), 32'(1));
    step();
    check("err n0 clear",   32'(cfg_err), 32'(0));
    check("err n0 cur_div", 32'(cur_div), 32'(3));
    check("err n0 state",   32'(dbg_state), 32'(IDLE));

    // Running N=6, drop en at cnt=2
    cfg_write(8'd6);
    check("n6 cur_div", 32'(cur_div), 32'(6));
    en = 1'b1;
    push_period(6);
    expect_cycles(3, "div6 head");
    en = 1'b0;
    expect_cycles(3, "div6 tail");
    check("div6 cnt5 state", 32'(dbg_state), 32'(RUN));
    step();
    check("div6 stop state", 32'(dbg_state), 32'(IDLE));
    for (int i = 0; i < 4; i++) begin
      check("div6 idle quiet", 32'({tick, out_clk}), 32'(2'b00));
      step();
    end

    // en together with an idle write: new ratio for the first period
    en = 1'b1; cfg_valid = 1'b1; cfg_div = 8'd3;
    step();
    cfg_valid = 1'b0;
    check("sim en cur_div", 32'(cur_div), 32'(3));
    check("sim en cnt0",    32'({tick, out_clk}), 32'(2'b11));
    exp_q.push_back(2'b00); exp_q.push_back(2'b00);
    push_period(3);
    expect_cycles(5, "sim en wave");
    en = 1'b0;
    step();
    check("sim en stop", 32'(dbg_state), 32'(IDLE));

    // Reset while PEND discards the pending ratio
    cfg_write(8'd6);
    en = 1'b1;
    step();
    step();
    cfg_write(8'd7);
    check("pre-rst state", 32'(dbg_state), 32'(PEND));
    check("pre-rst out",   32'(out_clk),   32'(1));
    #1 rst = 1'b0;
    #1;
    check("mid rst out_clk",   32'(out_clk),   32'(0));
    check("mid rst tick",      32'(tick),      32'(0));
    check("mid rst cfg_ready", 32'(cfg_ready), 32'(1));
    check("mid rst cur_div",   32'(cur_div),   32'(2));
    check("mid rst state",     32'(dbg_state), 32'(IDLE));
    rst = 1'b1;
    push_period(2); push_period(2);
    expect_cycles(4, "post rst wave");
    check("post rst cur_div", 32'(cur_div),   32'(2));
    check("post rst state",   32'(dbg_state), 32'(RUN));
    en = 1'b0;
    step();
    check("post rst stop", 32'(dbg_state), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
